decode_ctrl_unit: RTL and testbench

- Decode-stage instruction register plus control decoder plus operand-use-timing (Tuse) generator for the 5-stage MIPS pipeline.
- Latches the fetched instruction, then combinationally decodes the held instruction into datapath controls, an exception code, and per-source "needed register / stage of first use" information for the hazard unit.

---
 rtl/decode_ctrl_unit.sv | 189 ++++++++++++++++++
 tb/tb_decode_ctrl_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_unit.sv
// rtl/decode_ctrl_unit.sv - decode-stage instruction register, control decoder and Tuse generator
module decode_ctrl_unit #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        kill,
  input  logic [31:0] instr_in,
  output logic [31:0] IRO,
  output logic        regDst,
  output logic        reg31,
  output logic        siExt,
  output logic        shift2,
  output logic        regWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        regIn,
  output logic        memWrite,
  output logic        branch,
  output logic        j,
  output logic        jr,
  output logic        jl,
  output logic        md,
  output logic        eret,
  output logic [4:0]  ALUOP,
  output logic [3:0]  no,
  output logic [3:0]  tuse,
  output logic [4:0]  needreg1,
  output logic [4:0]  needreg2
);

  localparam int C_REGDST = 14, C_REG31 = 13, C_SIEXT = 12, C_SHIFT2 = 11, C_REGWRITE = 10;
  localparam int C_ALUSRC1 = 9, C_ALUSRC2 = 8, C_REGIN = 7, C_MEMWRITE = 6, C_BRANCH = 5;
  localparam int C_J = 4, C_JR = 3, C_JL = 2, C_MD = 1, C_ERET = 0;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_OR = 5'd2, ALU_AND = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4, ALU_SLL = 5'd5, ALU_LUI = 5'd6;

  logic [31:0] ir;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [14:0] ctl;
  logic [4:0]  alu;
  logic        ri;
  logic [1:0]  rs_t;
  logic [1:0]  rt_t;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ir <= NOP_WORD;
    end else if (!stall) begin
      ir <= instr_in;
    end
  end

  assign IRO   = ir;
  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];

  always_comb begin
    ctl  = '0;
    alu  = ALU_ADD;
    ri   = 1'b0;
    rs_t = 2'd3;
    rt_t = 2'd3;
    case (op)
      6'h00: begin
        case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: begin
            ctl[C_REGDST]   = 1'b1;
            ctl[C_REGWRITE] = 1'b1;
            rs_t = 2'd1;
            rt_t = 2'd1;
            case (funct)
              6'h23:   alu = ALU_SUB;
              6'h24:   alu = ALU_AND;
              6'h25:   alu = ALU_OR;
              6'h2a:   alu = ALU_SLT;
              default: alu = ALU_ADD;
            endcase
          end
          6'h00: begin
            // the all-zero word is the pipeline bubble and must decode to nothing at all
            if (ir != 32'h0) begin
              ctl[C_REGDST]   = 1'b1;
              ctl[C_REGWRITE] = 1'b1;
              ctl[C_ALUSRC1]  = 1'b1;
              alu  = ALU_SLL;
              rt_t = 2'd1;
            end
          end
          6'h08: begin
            ctl[C_JR] = 1'b1;
            rs_t = 2'd0;
          end
          6'h18, 6'h1a: begin
            ctl[C_MD] = 1'b1;
            rs_t = 2'd1;
            rt_t = 2'd1;
          end
          6'h10, 6'h12: begin
            ctl[C_MD]       = 1'b1;
            ctl[C_REGDST]   = 1'b1;
            ctl[C_REGWRITE] = 1'b1;
          end
          6'h11, 6'h13: begin
            ctl[C_MD] = 1'b1;
            rs_t = 2'd1;
          end
          default: ri = 1'b1;
        endcase
      end
      6'h09: begin
        ctl[C_REGWRITE] = 1'b1;
        ctl[C_SIEXT]    = 1'b1;
        ctl[C_ALUSRC2]  = 1'b1;
        rs_t = 2'd1;
      end
      6'h0d: begin
        ctl[C_REGWRITE] = 1'b1;
        ctl[C_ALUSRC2]  = 1'b1;
        alu  = ALU_OR;
        rs_t = 2'd1;
      end
      6'h0f: begin
        ctl[C_REGWRITE] = 1'b1;
        ctl[C_SHIFT2]   = 1'b1;
        ctl[C_ALUSRC2]  = 1'b1;
        alu = ALU_LUI;
      end
      6'h23: begin
        ctl[C_REGWRITE] = 1'b1;
        ctl[C_SIEXT]    = 1'b1;
        ctl[C_ALUSRC2]  = 1'b1;
        ctl[C_REGIN]    = 1'b1;
        rs_t = 2'd1;
      end
      6'h2b: begin
        ctl[C_SIEXT]    = 1'b1;
        ctl[C_ALUSRC2]  = 1'b1;
        ctl[C_MEMWRITE] = 1'b1;
        rs_t = 2'd1;
        rt_t = 2'd2;
      end
      6'h04: begin
        ctl[C_SIEXT]  = 1'b1;
        ctl[C_BRANCH] = 1'b1;
        alu  = ALU_SUB;
        rs_t = 2'd0;
        rt_t = 2'd0;
      end
      6'h02: ctl[C_J] = 1'b1;
      6'h03: begin
        ctl[C_J]        = 1'b1;
        ctl[C_JL]       = 1'b1;
        ctl[C_REG31]    = 1'b1;
        ctl[C_REGWRITE] = 1'b1;
      end
      6'h10: begin
        // COP0: eret is keyed on funct, mfc0/mtc0 on the rs field
        if (funct == 6'h18) begin
          ctl[C_ERET] = 1'b1;
        end else if (rs == 5'd0) begin
          ctl[C_REGWRITE] = 1'b1;
        end else if (rs == 5'd4) begin
          rt_t = 2'd2;
        end else begin
          ri = 1'b1;
        end
      end
      default: ri = 1'b1;
    endcase
  end

  assign {regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn,
          memWrite, branch, j, jr, jl, md, eret} = kill ? 15'h0 : ctl;
  assign ALUOP    = kill ? 5'd0 : alu;
  assign no       = (kill || !ri) ? 4'd0 : 4'd10;
  assign tuse     = {rt_t, rs_t};
  assign needreg1 = (rs_t != 2'd3) ? rs : 5'd0;
  assign needreg2 = (rt_t != 2'd3) ? rt : 5'd0;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// tb/tb_decode_ctrl_unit.sv - self-checking bench for decode_ctrl_unit
module tb_decode_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, kill;
  logic [31:0] instr_in;
  logic [31:0] IRO;
  logic        regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn;
  logic        memWrite, branch, j, jr, jl, md, eret;
  logic [4:0]  ALUOP;
  logic [3:0]  no;
  logic [3:0]  tuse;
  logic [4:0]  needreg1, needreg2;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_ir;

  decode_ctrl_unit #(.NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .kill(kill),
    .instr_in(instr_in), .IRO(IRO),
    .regDst(regDst), .reg31(reg31), .siExt(siExt), .shift2(shift2), .regWrite(regWrite),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .regIn(regIn), .memWrite(memWrite),
    .branch(branch), .j(j), .jr(jr), .jl(jl), .md(md), .eret(eret),
    .ALUOP(ALUOP), .no(no), .tuse(tuse), .needreg1(needreg1), .needreg2(needreg2)
  );

  always #5 clk = ~clk;

  logic [14:0] ctl_obs;
  logic [37:0] obs;
  assign ctl_obs = {regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn,
                    memWrite, branch, j, jr, jl, md, eret};
  assign obs = {ctl_obs, ALUOP, no, tuse, needreg1, needreg2};

  typedef enum {I_NOP, I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_JR, I_MULT, I_DIV,
                I_MFHI, I_MFLO, I_MTHI, I_MTLO, I_ADDIU, I_ORI, I_LUI, I_LW, I_SW,
                I_BEQ, I_J, I_JAL, I_ERET, I_MFC0, I_MTC0, I_RI} ins_t;

  function automatic ins_t classify(input logic [31:0] w);
    logic [5:0] f;
    f = w[5:0];
    if (w == 32'h0) return I_NOP;
    case (w[31:26])
      6'h00: case (f)
        6'h21: return I_ADDU;  6'h23: return I_SUBU;  6'h24: return I_AND;
        6'h25: return I_OR;    6'h2a: return I_SLT;   6'h00: return I_SLL;
        6'h08: return I_JR;    6'h18: return I_MULT;  6'h1a: return I_DIV;
        6'h10: return I_MFHI;  6'h12: return I_MFLO;  6'h11: return I_MTHI;
        6'h13: return I_MTLO;  default: return I_RI;
      endcase
      6'h09: return I_ADDIU; 6'h0d: return I_ORI; 6'h0f: return I_LUI;
      6'h23: return I_LW;    6'h2b: return I_SW;  6'h04: return I_BEQ;
      6'h02: return I_J;     6'h03: return I_JAL;
      6'h10: begin
        if (f == 6'h18) return I_ERET;
        if (w[25:21] == 5'd0) return I_MFC0;
        if (w[25:21] == 5'd4) return I_MTC0;
        return I_RI;
      end
      default: return I_RI;
    endcase
  endfunction

  // expected outputs from instruction class membership, same bit order as obs
  function automatic logic [37:0] model(input logic [31:0] w, input logic k);
    ins_t m;
    logic [14:0] c;
    logic [4:0]  a;
    logic [3:0]  e;
    logic [1:0]  ts, tt;
    m = classify(w);
    c[14] = m inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_MFHI, I_MFLO};
    c[13] = (m == I_JAL);
    c[12] = m inside {I_ADDIU, I_LW, I_SW, I_BEQ};
    c[11] = (m == I_LUI);
    c[10] = m inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_MFHI, I_MFLO,
                      I_ADDIU, I_ORI, I_LUI, I_LW, I_JAL, I_MFC0};
    c[9]  = (m == I_SLL);
    c[8]  = m inside {I_ADDIU, I_ORI, I_LUI, I_LW, I_SW};
    c[7]  = (m == I_LW);
    c[6]  = (m == I_SW);
    c[5]  = (m == I_BEQ);
    c[4]  = m inside {I_J, I_JAL};
    c[3]  = (m == I_JR);
    c[2]  = (m == I_JAL);
    c[1]  = m inside {I_MULT, I_DIV, I_MFHI, I_MFLO, I_MTHI, I_MTLO};
    c[0]  = (m == I_ERET);
    case (m)
      I_SUBU, I_BEQ: a = 5'd1;
      I_OR, I_ORI:   a = 5'd2;
      I_AND:         a = 5'd3;
      I_SLT:         a = 5'd4;
      I_SLL:         a = 5'd5;
      I_LUI:         a = 5'd6;
      default:       a = 5'd0;
    endcase
    e = (m == I_RI) ? 4'd10 : 4'd0;
    if (m inside {I_BEQ, I_JR}) ts = 2'd0;
    else if (m inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_MULT, I_DIV, I_MTHI, I_MTLO,
                       I_ADDIU, I_ORI, I_LW, I_SW}) ts = 2'd1;
    else ts = 2'd3;
    if (m == I_BEQ) tt = 2'd0;
    else if (m inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_MULT, I_DIV}) tt = 2'd1;
    else if (m inside {I_SW, I_MTC0}) tt = 2'd2;
    else tt = 2'd3;
    if (k) begin
      c = '0;
      a = '0;
      e = '0;
    end
    return {c, a, e, tt, ts, (ts != 2'd3) ? w[25:21] : 5'd0, (tt != 2'd3) ? w[20:16] : 5'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] base [0:23];
    logic [31:0] mask [0:23];
    int k;
    int idx;
    base = '{32'h21, 32'h23, 32'h24, 32'h25, 32'h2a, 32'h00, 32'h08, 32'h18, 32'h1a, 32'h10,
             32'h12, 32'h11, 32'h13, 32'h24000000, 32'h34000000, 32'h3c000000, 32'h8c000000,
             32'hac000000, 32'h10000000, 32'h08000000, 32'h0c000000, 32'h42000018,
             32'h40000000, 32'h40800000};
    for (int i = 0; i < 24; i++) mask[i] = (i < 13) ? 32'h03ff_ffc0 : 32'h03ff_ffff;
    mask[21] = 32'h0;
    mask[22] = 32'h001f_f800;
    mask[23] = 32'h001f_f800;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom;
    if (k == 1) return 32'h0;
    idx = $urandom_range(0, 23);
    return base[idx] | ($urandom & mask[idx]);
  endfunction

  task automatic tick();
    if (reset || flush) m_ir = 32'h0;
    else if (!stall) m_ir = instr_in;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    instr_in = w;
    stall = 1'b0;
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    instr_in = 32'hdead_beef;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (IRO !== 32'h0) begin n_fail++; $display("FAIL reset_iro: got %h expected %h", IRO, 32'h0); end
    n_chk++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", regWrite); end
    n_chk++; if (tuse !== 4'hF) begin n_fail++; $display("FAIL reset_tuse: got %h expected f", tuse); end
    n_chk++; if ({needreg1, needreg2} !== 10'h0) begin n_fail++; $display("FAIL reset_needreg: got %h/%h expected 0/0", needreg1, needreg2); end
    n_chk++; if ({ctl_obs, ALUOP, no} !== 24'h0) begin n_fail++; $display("FAIL reset_controls: got %h expected 0", {ctl_obs, ALUOP, no}); end
  endtask

  task automatic test_lw();
    load(32'h8C880004);
    n_chk++; if ({regWrite, regIn, ALUSrc2, siExt} !== 4'hF) begin n_fail++; $display("FAIL lw_ctl: got %b expected 1111", {regWrite, regIn, ALUSrc2, siExt}); end
    n_chk++; if (ALUOP !== 5'd0) begin n_fail++; $display("FAIL lw_aluop: got %0d expected 0", ALUOP); end
    n_chk++; if (tuse !== 4'b1101) begin n_fail++; $display("FAIL lw_tuse: got %h expected d", tuse); end
    n_chk++; if ({needreg1, needreg2} !== {5'd4, 5'd0}) begin n_fail++; $display("FAIL lw_needreg: got %0d/%0d expected 4/0", needreg1, needreg2); end
    n_chk++; if (obs !== model(32'h8C880004, 1'b0)) begin n_fail++; $display("FAIL lw_model: got %h expected %h", obs, model(32'h8C880004, 1'b0)); end
  endtask

  task automatic test_beq_sw();
    load(32'h10850003);
    n_chk++; if ({branch, ALUOP} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL beq_ctl: got %b/%0d expected 1/1", branch, ALUOP); end
    n_chk++; if (tuse !== 4'h0) begin n_fail++; $display("FAIL beq_tuse: got %h expected 0", tuse); end
    n_chk++; if ({needreg1, needreg2} !== {5'd4, 5'd5}) begin n_fail++; $display("FAIL beq_needreg: got %0d/%0d expected 4/5", needreg1, needreg2); end
    load(32'hAC850000);
    n_chk++; if (memWrite !== 1'b1) begin n_fail++; $display("FAIL sw_memwrite: got %b expected 1", memWrite); end
    n_chk++; if (tuse !== 4'h9) begin n_fail++; $display("FAIL sw_tuse: got %h expected 9", tuse); end
  endtask

  task automatic test_jal_eret();
    load(32'h0C000010);
    n_chk++; if ({j, jl, reg31, regWrite} !== 4'hF) begin n_fail++; $display("FAIL jal_ctl: got %b expected 1111", {j, jl, reg31, regWrite}); end
    load(32'h42000018);
    n_chk++; if ({eret, no} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL eret_ctl: got %b/%0d expected 1/0", eret, no); end
  endtask

  task automatic test_ri();
    load(32'hFC000000);
    n_chk++; if (no !== 4'd10) begin n_fail++; $display("FAIL ri_no: got %0d expected 10", no); end
    n_chk++; if ({ctl_obs, ALUOP} !== 20'h0) begin n_fail++; $display("FAIL ri_controls: got %h expected 0", {ctl_obs, ALUOP}); end
  endtask

  task automatic test_stall_flush();
    load(32'h00221821);
    stall = 1'b1;
    instr_in = 32'h8C880004;
    tick();
    instr_in = 32'h10850003;
    tick();
    n_chk++; if (IRO !== 32'h00221821) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", IRO, 32'h00221821); end
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    n_chk++; if (IRO !== 32'h0) begin n_fail++; $display("FAIL stall_flush: got %h expected 0", IRO); end
  endtask

  task automatic test_kill();
    load(32'h00221821);
    kill = 1'b1;
    #1;
    n_chk++; if ({ctl_obs, ALUOP, no} !== 24'h0) begin n_fail++; $display("FAIL kill_controls: got %h expected 0", {ctl_obs, ALUOP, no}); end
    n_chk++; if ({tuse, needreg1, needreg2} !== {4'h5, 5'd1, 5'd2}) begin n_fail++; $display("FAIL kill_needreg: got %h/%0d/%0d expected 5/1/2", tuse, needreg1, needreg2); end
    kill = 1'b0;
    #1;
    n_chk++; if ({regDst, regWrite, ALUOP} !== {2'b11, 5'd0}) begin n_fail++; $display("FAIL unkill_addu: got %b expected 1100000", {regDst, regWrite, ALUOP}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      instr_in = rand_instr();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      kill = ($urandom_range(0, 5) == 0);
      tick();
      n_chk++; if (IRO !== m_ir) begin n_fail++; $display("FAIL rand_iro[%0d]: got %h expected %h", i, IRO, m_ir); end
      n_chk++; if (obs !== model(m_ir, kill)) begin n_fail++; $display("FAIL rand_decode[%0d] ir=%h kill=%b: got %h expected %h", i, m_ir, kill, obs, model(m_ir, kill)); end
    end
    stall = 1'b0;
    flush = 1'b0;
    kill = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    kill = 1'b0;
    instr_in = 32'h0;
    m_ir = 32'h0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_beq_sw();
    test_jal_eret();
    test_ri();
    test_stall_flush();
    test_kill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
